// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch/decode/execute/memory stages:
// default widths, opcode field position and the fetch state encoding.
package fetch_stage_pkg;

  localparam int DEF_PC_W = 12;
  localparam int DEF_IR_W = 16;
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int OPC_W    = OPC_HI - OPC_LO + 1;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching the ROM word that returns while decode is stalled.
module fetch_skid
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int IR_W = DEF_IR_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            clr_i,
  input  logic [IR_W-1:0] ir_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            valid_o,
  output logic [IR_W-1:0] ir_o,
  output logic [PC_W-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [IR_W-1:0] ir_q;
  logic [PC_W-1:0] pc_q;

  always_comb begin
    valid_d = valid_q;
    if (clr_i)       valid_d = 1'b0;
    else if (load_i) valid_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  // Payload is only meaningful while valid_q is set, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      ir_q <= ir_i;
      pc_q <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign ir_o    = ir_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a synchronous ROM, registers the fetched word
// for decode, and handles stall (via a one-entry skid) and redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int IR_W = DEF_IR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [IR_W-1:0]  imem_data,
  output logic             f_valid,
  output logic [IR_W-1:0]  f_ir,
  output logic [PC_W-1:0]  f_pc,
  output logic [OPC_W-1:0] f_codop,
  output logic [CNT_W-1:0] bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic             req_valid_q, req_valid_d;
  logic             f_valid_q, f_valid_d;
  logic [IR_W-1:0]  f_ir_q, f_ir_d;
  logic [PC_W-1:0]  f_pc_q, f_pc_d;
  logic [OPC_W-1:0] f_codop_q, f_codop_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic             issue, take_skid, take_mem, skid_load, skid_clr;
  logic             skid_valid;
  logic [IR_W-1:0]  skid_ir;
  logic [PC_W-1:0]  skid_pc;

  fetch_skid #(
    .PC_W (PC_W),
    .IR_W (IR_W)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .ir_i    (imem_data),
    .pc_i    (req_pc_q),
    .valid_o (skid_valid),
    .ir_o    (skid_ir),
    .pc_o    (skid_pc)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = S_FILL;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FILL;
        S_FILL:  if (f_valid_d) state_d = S_RUN;
        S_RUN:   if (stall) state_d = S_HOLD;
        S_HOLD:  if (!stall) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: control outputs; redirect overrides stall
  always_comb begin
    issue     = !redirect && !stall;
    take_skid = issue && skid_valid;
    take_mem  = issue && !skid_valid;
    skid_load = !redirect && stall && req_valid_q;
    skid_clr  = redirect || take_skid;
  end

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = issue;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d     = pc_q + 1'b1;
      req_pc_d = pc_q;
    end
  end

  always_comb begin
    f_valid_d = f_valid_q;
    f_ir_d    = f_ir_q;
    f_pc_d    = f_pc_q;
    if (redirect) begin
      f_valid_d = 1'b0;
    end else if (take_skid) begin
      f_valid_d = 1'b1;
      f_ir_d    = skid_ir;
      f_pc_d    = skid_pc;
    end else if (take_mem) begin
      f_valid_d = req_valid_q;
      f_ir_d    = imem_data;
      f_pc_d    = req_pc_q;
    end
    f_codop_d = f_ir_d[OPC_HI:OPC_LO];
  end

  // The cycle spent in S_IDLE is the reset cycle itself and is not a bubble.
  always_comb begin
    bubble_d = bubble_q;
    if (!f_valid_q && state_q != S_IDLE) bubble_d = sat_inc(bubble_q);
  end

  // Stage boundary: fetch registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= '0;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      f_valid_q   <= 1'b0;
      f_ir_q      <= '0;
      f_pc_q      <= '0;
      f_codop_q   <= '0;
      bubble_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      f_valid_q   <= f_valid_d;
      f_ir_q      <= f_ir_d;
      f_pc_q      <= f_pc_d;
      f_codop_q   <= f_codop_d;
      bubble_q    <= bubble_d;
    end
  end

  // No read is issued while stalled, so skid and an in-flight read never coexist at release.
  a_no_skid_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(issue && skid_valid && req_valid_q));

  assign imem_addr  = pc_q;
  assign f_valid    = f_valid_q;
  assign f_ir       = f_ir_q;
  assign f_pc       = f_pc_q;
  assign f_codop    = f_codop_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: ROM model, queue-based reference of the fetch stream,
// directed scenarios and a randomized run.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk, rst_n, stall, redirect;
  logic [11:0] redirect_pc, imem_addr, f_pc;
  logic [15:0] imem_data, f_ir, bubble_cnt;
  logic        f_valid;
  logic [3:0]  f_codop;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [4096];

  // Reference model: next address to fetch, reads not yet delivered, visible output.
  logic [11:0] m_next, m_fpc;
  logic        m_fv, m_live;
  logic [15:0] m_bub;
  logic [11:0] m_q[$];

  fetch_stage #(.PC_W(12), .IR_W(16)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .f_valid     (f_valid),
    .f_ir        (f_ir),
    .f_pc        (f_pc),
    .f_codop     (f_codop),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_next = '0; m_q.delete(); m_fv = 1'b0; m_fpc = '0; m_bub = '0; m_live = 1'b0;
    end else begin
      if (m_live && !m_fv && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
      m_live = 1'b1;
      if (redirect) begin
        m_q.delete(); m_next = redirect_pc; m_fv = 1'b0;
      end else if (!stall) begin
        if (m_q.size() > 0) begin m_fpc = m_q.pop_front(); m_fv = 1'b1; end
        else m_fv = 1'b0;
        m_q.push_back(m_next);
        m_next = m_next + 12'd1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (f_valid !== 1'b0 || f_pc !== 12'h0 || f_ir !== 16'h0 || f_codop !== 4'h0 || bubble_cnt !== 16'h0) begin
      errors++; $display("FAIL reset outputs: got v=%0b pc=%h ir=%h op=%h bub=%0d, want all zero", f_valid, f_pc, f_ir, f_codop, bubble_cnt);
    end
    checks++;
    if (imem_addr !== 12'h0 || dut.state_q !== S_IDLE) begin
      errors++; $display("FAIL reset addr/state: got addr=%h state=%0d, want 0/%0d", imem_addr, dut.state_q, S_IDLE);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (f_valid !== m_fv || (m_fv && (f_pc !== m_fpc || f_ir !== rom[m_fpc] || f_codop !== rom[m_fpc][15:12]))) begin
        errors++; $display("FAIL stream out: got v=%0b pc=%h ir=%h op=%h, want v=%0b pc=%h", f_valid, f_pc, f_ir, f_codop, m_fv, m_fpc);
      end
      checks++;
      if (imem_addr !== m_next) begin errors++; $display("FAIL stream addr: got %h want %h", imem_addr, m_next); end
      if (k >= 1) begin
        checks++;
        if (f_valid !== 1'b1 || f_pc !== 12'(k - 1) || f_ir !== 16'(16'h1000 + k - 1)) begin
          errors++; $display("FAIL stream seq: got v=%0b pc=%h ir=%h, want pc=%h ir=%h", f_valid, f_pc, f_ir, 12'(k - 1), 16'(16'h1000 + k - 1));
        end
      end
    end
    checks++;
    if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL stream bubble: got %0d want 1", bubble_cnt); end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    n = 0;
    while (!(m_fv && m_fpc == 12'd2) && n < 10) begin tick(); n++; end
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 12'd2) begin errors++; $display("FAIL stall setup: got v=%0b pc=%h want pc=002", f_valid, f_pc); end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (f_valid !== 1'b1 || f_pc !== 12'd2 || f_ir !== 16'h1002) begin
        errors++; $display("FAIL stall hold: got v=%0b pc=%h ir=%h want pc=002 ir=1002", f_valid, f_pc, f_ir);
      end
      checks++;
      if (dut.state_q !== S_HOLD) begin errors++; $display("FAIL stall state: got %0d want %0d", dut.state_q, S_HOLD); end
    end
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (f_valid !== 1'b1 || f_pc !== 12'(3 + k) || f_ir !== rom[12'(3 + k)]) begin
        errors++; $display("FAIL stall release: got v=%0b pc=%h ir=%h want pc=%h", f_valid, f_pc, f_ir, 12'(3 + k));
      end
      checks++;
      if (f_valid !== m_fv || (m_fv && f_pc !== m_fpc) || imem_addr !== m_next || bubble_cnt !== m_bub) begin
        errors++; $display("FAIL stall model: got v=%0b pc=%h addr=%h bub=%0d want v=%0b pc=%h addr=%h bub=%0d", f_valid, f_pc, imem_addr, bubble_cnt, m_fv, m_fpc, m_next, m_bub);
      end
    end
  endtask

  task automatic test_redirect();
    int n;
    n = 0;
    while (!(m_fv && m_fpc == 12'd7) && n < 20) begin tick(); n++; end
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 12'd7) begin errors++; $display("FAIL redirect setup: got v=%0b pc=%h want pc=007", f_valid, f_pc); end
    redirect = 1'b1; redirect_pc = 12'h0A5;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checks++;
      if (f_valid !== (k >= 2) || (k == 2 && (f_pc !== 12'h0A5 || f_ir !== rom[12'h0A5] || f_codop !== rom[12'h0A5][15:12]))) begin
        errors++; $display("FAIL redirect seq[%0d]: got v=%0b pc=%h ir=%h want v=%0b pc=0a5 ir=%h", k, f_valid, f_pc, f_ir, (k >= 2), rom[12'h0A5]);
      end
      checks++;
      if (f_valid !== m_fv || (m_fv && f_pc !== m_fpc) || imem_addr !== m_next || bubble_cnt !== m_bub) begin
        errors++; $display("FAIL redirect model: got v=%0b pc=%h addr=%h bub=%0d want v=%0b pc=%h addr=%h bub=%0d", f_valid, f_pc, imem_addr, bubble_cnt, m_fv, m_fpc, m_next, m_bub);
      end
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 12'h3C0;
    tick();
    redirect = 1'b0;
    checks++;
    if (dut.u_skid.valid_q !== 1'b0 || f_valid !== 1'b0) begin
      errors++; $display("FAIL redir+stall clear: got skid=%0b v=%0b want 0/0", dut.u_skid.valid_q, f_valid);
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) stall = 1'b0;
      tick();
      checks++;
      if (f_valid !== (k >= 3) || (k == 3 && (f_pc !== 12'h3C0 || f_ir !== rom[12'h3C0]))) begin
        errors++; $display("FAIL redir+stall seq[%0d]: got v=%0b pc=%h want v=%0b pc=3c0", k, f_valid, f_pc, (k >= 3));
      end
      checks++;
      if (f_valid !== m_fv || (m_fv && f_pc !== m_fpc) || imem_addr !== m_next || bubble_cnt !== m_bub) begin
        errors++; $display("FAIL redir+stall model: got v=%0b pc=%h addr=%h bub=%0d want v=%0b pc=%h addr=%h bub=%0d", f_valid, f_pc, imem_addr, bubble_cnt, m_fv, m_fpc, m_next, m_bub);
      end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] want [3];
    want[0] = 12'hFFE; want[1] = 12'hFFF; want[2] = 12'h000;
    redirect = 1'b1; redirect_pc = 12'hFFE;
    tick();
    redirect = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (f_valid !== 1'b1 || f_pc !== want[k] || f_ir !== rom[want[k]]) begin
        errors++; $display("FAIL wrap seq[%0d]: got v=%0b pc=%h ir=%h want pc=%h", k, f_valid, f_pc, f_ir, want[k]);
      end
    end
    checks++;
    if (imem_addr !== m_next || m_next !== 12'h002) begin errors++; $display("FAIL wrap addr: got %h want 002", imem_addr); end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 12'h100;
    tick();
    redirect_pc = 12'h200;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (f_valid !== (k >= 1) || (k >= 1 && f_pc !== 12'(12'h200 + k - 1))) begin
        errors++; $display("FAIL b2b redirect[%0d]: got v=%0b pc=%h want v=%0b pc=%h", k, f_valid, f_pc, (k >= 1), 12'(12'h200 + k - 1));
      end
      checks++;
      if (f_valid !== m_fv || (m_fv && f_pc !== m_fpc) || imem_addr !== m_next || bubble_cnt !== m_bub) begin
        errors++; $display("FAIL b2b model: got v=%0b pc=%h addr=%h bub=%0d want v=%0b pc=%h addr=%h bub=%0d", f_valid, f_pc, imem_addr, bubble_cnt, m_fv, m_fpc, m_next, m_bub);
      end
    end
  endtask

  task automatic test_reset_hold();
    stall = 1'b1;
    tick();
    checks++;
    if (dut.u_skid.valid_q !== 1'b1 || dut.state_q !== S_HOLD) begin
      errors++; $display("FAIL hold setup: got skid=%0b state=%0d want 1/%0d", dut.u_skid.valid_q, dut.state_q, S_HOLD);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (f_valid !== 1'b0 || f_pc !== 12'h0 || f_ir !== 16'h0 || f_codop !== 4'h0 || bubble_cnt !== 16'h0 || imem_addr !== 12'h0) begin
      errors++; $display("FAIL hold reset outputs: got v=%0b pc=%h ir=%h op=%h bub=%0d addr=%h want zeros", f_valid, f_pc, f_ir, f_codop, bubble_cnt, imem_addr);
    end
    checks++;
    if (dut.state_q !== S_IDLE || dut.u_skid.valid_q !== 1'b0) begin
      errors++; $display("FAIL hold reset state: got state=%0d skid=%0b want %0d/0", dut.state_q, dut.u_skid.valid_q, S_IDLE);
    end
    rst_n = 1'b1; stall = 1'b0;
    tick(); tick();
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 12'h0 || f_ir !== 16'h1000 || bubble_cnt !== 16'd1) begin
      errors++; $display("FAIL hold restart: got v=%0b pc=%h ir=%h bub=%0d want 1/000/1000/1", f_valid, f_pc, f_ir, bubble_cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 6);
      redirect_pc = 12'($urandom);
      tick();
      checks++;
      if (f_valid !== m_fv || (m_fv && (f_pc !== m_fpc || f_ir !== rom[m_fpc] || f_codop !== rom[m_fpc][15:12]))) begin
        errors++; $display("FAIL random out[%0d]: got v=%0b pc=%h ir=%h op=%h want v=%0b pc=%h", k, f_valid, f_pc, f_ir, f_codop, m_fv, m_fpc);
      end
      checks++;
      if (imem_addr !== m_next || bubble_cnt !== m_bub) begin
        errors++; $display("FAIL random addr/bub[%0d]: got addr=%h bub=%0d want addr=%h bub=%0d", k, imem_addr, bubble_cnt, m_next, m_bub);
      end
    end
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = (i < 8) ? 16'(16'h1000 + i) : 16'($urandom);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    m_next = '0; m_fpc = '0; m_fv = 1'b0; m_live = 1'b0; m_bub = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_back_to_back();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
